// File: rtl/multdiv_ctrl.sv
// Sequencer between the issue pipeline and the iterative multdiv unit.
// Accepts one operation at a time, fires a single start pulse, and waits
// for the unit to report completion. A timeout watchdog makes sure a hung
// unit still produces a write-back. The write-back result is held until
// the consumer takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operation, operand outputs parked at 0
// START | one-cycle start pulse to multdiv, counter cleared
// BUSY  | counting cycles, waiting for a qualifying md_resultRDY
// DONE  | write-back valid, held until wb_ready
module multdiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int MIN_LAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        flush,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_exception,
  output logic        wb_timeout,
  input  logic        wb_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);
  localparam logic [5:0] MIN_LAT_C = 6'(MIN_LAT);
  localparam logic [5:0] CNT_MAX   = 6'h3F;

  state_t      state;
  state_t      state_nxt;
  logic        op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic [5:0]  cnt_q;
  logic        accept;
  logic        div_zero;
  logic        rdy_ok;
  logic        tmo_hit;

  // issue_ready is forced low while reset is held so every output reads 0
  assign issue_ready = reset_n & (state == IDLE) & ~flush;
  assign accept      = issue_valid & issue_ready;
  assign div_zero    = issue_op & (issue_b == 32'd0);
  assign rdy_ok      = (state == BUSY) & md_resultRDY & (cnt_q >= MIN_LAT_C);
  assign tmo_hit     = (state == BUSY) & (cnt_q >= TIMEOUT_C);
  assign busy        = (state != IDLE);
  assign wb_valid    = (state == DONE);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode, start pulses and operand presentation
  always_comb begin
    state_nxt    = state;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    md_operandA  = 32'd0;
    md_operandB  = 32'd0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = div_zero ? DONE : START;
      end
      START: begin
        md_ctrl_MULT = ~op_q;
        md_ctrl_DIV  = op_q;
        md_operandA  = a_q;
        md_operandB  = b_q;
        state_nxt    = BUSY;
      end
      BUSY: begin
        md_operandA = a_q;
        md_operandB = b_q;
        if (rdy_ok || tmo_hit) state_nxt = DONE;
      end
      DONE: begin
        if (wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt    = IDLE;
      md_ctrl_MULT = 1'b0;
      md_ctrl_DIV  = 1'b0;
    end
  end

  // Operation capture on accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= 1'b0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      rd_q <= 5'd0;
    end else if (accept) begin
      op_q <= issue_op;
      a_q  <= issue_a;
      b_q  <= issue_b;
      rd_q <= issue_rd;
    end
  end

  // Saturating cycle counter, restarted by the start pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 6'd0;
    end else if (flush || state == START) begin
      cnt_q <= 6'd0;
    end else if (state == BUSY && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  // Write-back registers; a qualifying result takes priority over the timeout
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_exception <= 1'b0;
      wb_timeout   <= 1'b0;
    end else if (flush || (state == DONE && wb_ready)) begin
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_exception <= 1'b0;
      wb_timeout   <= 1'b0;
    end else if (accept && div_zero) begin
      wb_data      <= 32'd0;
      wb_rd        <= issue_rd;
      wb_exception <= 1'b1;
      wb_timeout   <= 1'b0;
    end else if (rdy_ok) begin
      wb_data      <= md_result;
      wb_rd        <= rd_q;
      wb_exception <= md_exception;
      wb_timeout   <= 1'b0;
    end else if (tmo_hit) begin
      wb_data      <= 32'd0;
      wb_rd        <= rd_q;
      wb_exception <= 1'b1;
      wb_timeout   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomised scoreboard bench for multdiv_ctrl. A responder process plays
// the multdiv unit, a sink drives wb_ready, and a monitor pops expected
// write-backs whenever wb_valid rises and keeps checking them while held.
module tb_multdiv_ctrl;
  localparam int TIMEOUT = 40;
  localparam int MIN_LAT = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;
  logic        wb_timeout;
  logic        wb_ready;
  logic        busy;

  multdiv_ctrl #(.TIMEOUT(TIMEOUT), .MIN_LAT(MIN_LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a),
    .issue_b(issue_b), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .flush(flush),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_exception(wb_exception), .wb_timeout(wb_timeout), .wb_ready(wb_ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        exc;
    logic        tmo;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        cfg_op;
  logic [31:0] cfg_a;
  logic [31:0] cfg_b;
  int          cfg_rdy;
  bit          cfg_spur;
  logic        cfg_exc;
  int          cfg_wbd = 0;
  int          pulse_cnt = 0;
  bit          resp_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Arithmetic the multdiv unit is expected to perform (signed, low 32 bits)
  function automatic logic [31:0] md_calc(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] q;
    p = 64'($signed(a)) * 64'($signed(b));
    q = (b == 32'd0) ? 32'sd0 : $signed(a) / $signed(b);
    return op ? q : p[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_issue_ready"}, issue_ready, 0);
    check({tag, "_md_ctrl"}, {md_ctrl_MULT, md_ctrl_DIV}, 0);
    check({tag, "_opA"}, md_operandA, 0);
    check({tag, "_opB"}, md_operandB, 0);
    check({tag, "_wb_flags"}, {wb_valid, wb_exception, wb_timeout}, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_wb_rd"}, wb_rd, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || resp_busy) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) fail_bound("wait_idle");
  endtask

  // mode 0: normal, 1: flush at counter 2, 2: reset pulse mid-BUSY
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdy, input bit spur,
                        input logic exc, input int wbd, input int mode);
    exp_t e;
    int   lat_exp;
    int   lat;
    int   n;
    int   p0;
    int   pulses_exp;
    wait_idle();
    cfg_op = op; cfg_a = a; cfg_b = b; cfg_rdy = rdy;
    cfg_spur = spur; cfg_exc = exc; cfg_wbd = wbd;
    if (op && b == 32'd0) begin
      e = '{32'd0, 1'b1, 1'b0, rd}; lat_exp = 0; pulses_exp = 0;
    end else if (rdy >= MIN_LAT && rdy <= TIMEOUT) begin
      e = '{md_calc(op, a, b), exc, 1'b0, rd}; lat_exp = rdy + 2; pulses_exp = 1;
    end else begin
      e = '{32'd0, 1'b1, 1'b1, rd}; lat_exp = TIMEOUT + 2; pulses_exp = 1;
    end
    if (mode == 0) exp_q.push_back(e);
    p0 = pulse_cnt;
    @(negedge clock);
    issue_valid = 1'b1; issue_op = op; issue_a = a; issue_b = b; issue_rd = rd;
    n = 0;
    while (!issue_ready && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) fail_bound("accept");
    @(negedge clock);
    issue_valid = 1'b0;
    issue_op = 1'($urandom_range(0, 1)); issue_a = $urandom; issue_b = $urandom;
    issue_rd = 5'($urandom);
    case (mode)
      0: begin
        lat = 0;
        while (!wb_valid && lat < TIMEOUT + 10) begin
          @(negedge clock);
          lat++;
        end
        check("latency", lat, lat_exp);
      end
      1: begin
        repeat (3) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_wb_valid", wb_valid, 0);
      end
      default: begin
        repeat (6) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1 check("midrst_release_ready", issue_ready, 1);
      end
    endcase
    wait_idle();
    check("pulse_count", pulse_cnt - p0, pulses_exp);
    repeat (3) @(negedge clock);
  endtask

  // Behavioural stand-in for the multdiv unit
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          last;
    md_resultRDY = 1'b0;
    md_result    = 32'd0;
    md_exception = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && (md_ctrl_MULT || md_ctrl_DIV)) begin
        resp_busy = 1'b1;
        pulse_cnt++;
        check("pulse_kind", {md_ctrl_MULT, md_ctrl_DIV}, cfg_op ? 2'b01 : 2'b10);
        check("start_opA", md_operandA, cfg_a);
        check("start_opB", md_operandB, cfg_b);
        ra = md_operandA;
        rb = md_operandB;
        last = (cfg_rdy > 1) ? cfg_rdy : 1;
        for (int c = 0; c <= last; c++) begin
          @(negedge clock);
          if (c == 0) check("pulse_width", {md_ctrl_MULT, md_ctrl_DIV}, 0);
          if (c == 0 && busy) begin
            check("busy_opA", md_operandA, cfg_a);
            check("busy_opB", md_operandB, cfg_b);
          end
          if (c == cfg_rdy) begin
            md_resultRDY = 1'b1; md_result = md_calc(cfg_op, ra, rb); md_exception = cfg_exc;
          end else if (cfg_spur && c == 1) begin
            md_resultRDY = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b1;
          end else begin
            md_resultRDY = 1'b0; md_result = 32'hBAD0_BAD0; md_exception = 1'b1;
          end
        end
        @(negedge clock);
        md_resultRDY = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Write-back consumer: holds off wb_ready for cfg_wbd cycles of wb_valid
  initial begin
    int waited;
    waited = 0;
    wb_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (wb_valid) begin
        if (waited >= cfg_wbd) wb_ready = 1'b1;
        else begin
          wb_ready = 1'b0;
          waited++;
        end
      end else begin
        wb_ready = 1'b0;
        waited = 0;
      end
    end
  end

  // Scoreboard monitor: pop on wb_valid rise, recheck every held cycle
  initial begin
    exp_t cur;
    bit   have;
    bit   prev;
    have = 1'b0;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (wb_valid) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_wb: got wb_valid with rd=%0d data=0x%08h, expected none at %0t",
                     wb_rd, wb_data, $time);
            have = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          check("wb_data", wb_data, cur.data);
          check("wb_rd", wb_rd, cur.rd);
          check("wb_exception", wb_exception, cur.exc);
          check("wb_timeout", wb_timeout, cur.tmo);
          check("done_issue_ready", issue_ready, 0);
        end
      end
      prev = wb_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    int          rdy;
    issue_valid = 1'b0; issue_op = 1'b0; issue_a = 32'd0; issue_b = 32'd0;
    issue_rd = 5'd0; flush = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #3 check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_reset_ready", issue_ready, 1);
    check("post_reset_busy", busy, 0);

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 3, 1'b0, 1'b0, 0, 0);
    run_op(1'b1, 32'd100, 32'd0, 5'd9, 3, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 32'd12345, 32'd678, 5'd2, -1, 1'b1, 1'b0, 1, 0);
    run_op(1'b0, 32'd11, 32'd13, 5'd4, 3, 1'b0, 1'b0, 0, 1);
    run_op(1'b1, 32'd1000, 32'd7, 5'd6, MIN_LAT, 1'b0, 1'b1, 5, 0);
    run_op(1'b0, 32'hFFFF_FFFB, 32'd9, 5'd7, TIMEOUT, 1'b0, 1'b0, 0, 0);
    run_op(1'b1, 32'd77, 32'd5, 5'd8, TIMEOUT + 1, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 32'd3, 32'd4, 5'd10, MIN_LAT - 1, 1'b0, 1'b0, 0, 0);
    run_op(1'b1, 32'd500, 32'd3, 5'd11, 8, 1'b0, 1'b0, 0, 2);
    run_op(1'b0, 32'd2, 32'd3, 5'd12, MIN_LAT, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (b == 32'hFFFF_FFFF) b = 32'd7;
      case ($urandom_range(0, 9))
        0:       rdy = -1;
        1, 2:    rdy = $urandom_range(0, TIMEOUT + 3);
        default: rdy = $urandom_range(0, 8);
      endcase
      run_op(op, a, b, 5'($urandom), rdy, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end

    wait_idle();
    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: max cycles to wait for md_resultRDY after a start pulse.
REQ-002 SHALL have parameter MIN_LAT, default 2: cycles after the start pulse during which md_resultRDY is ignored.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port issue_valid  input  1  pipeline requests an operation.
REQ-006 SHALL have port issue_op  input  1  0 = multiply, 1 = divide.
REQ-007 SHALL have port issue_a / issue_b  input  32 each  operands A and B.
REQ-008 SHALL have port issue_rd  input  5  destination register tag.
REQ-009 SHALL have port issue_ready  output  1  request accepted this cycle when high with issue_valid.
REQ-010 SHALL have port flush  input  1  synchronous cancel of any in-flight or pending operation.
REQ-011 SHALL have port md_operandA / md_operandB  output  32 each  operands to multdiv.
REQ-012 SHALL have port md_ctrl_MULT / md_ctrl_DIV  output  1 each  start pulses to multdiv.
REQ-013 SHALL have port md_result  input  32  multdiv data_result.
REQ-014 SHALL have port md_exception / md_resultRDY  input  1 each  multdiv status.
REQ-015 SHALL have port wb_valid  output  1  result available.
REQ-016 SHALL have port wb_data  output  32  result value.
REQ-017 SHALL have port wb_rd  output  5  destination tag.
REQ-018 SHALL have port wb_exception  output  1  result exception.
REQ-019 SHALL have port wb_timeout  output  1  multdiv failed to complete.
REQ-020 SHALL have port wb_ready  input  1  consumer accepts the result.
REQ-021 SHALL have port busy  output  1  state != IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, START, BUSY, DONE.
REQ-023 issue_ready SHALL equal (state==IDLE) & ~flush; accept = issue_valid & issue_ready.
REQ-024 On accept, SHALL register op, A, B, rd; next state START, except divide with issue_b==0, which SHALL go directly to DONE with wb_data=0, wb_exception=1, and no start pulse.
REQ-025 In START, SHALL assert exactly one of md_ctrl_MULT/md_ctrl_DIV for exactly one cycle, per op; next state BUSY; cycle counter cleared to 0.
REQ-026 md_operandA/B SHALL present the registered operands, held stable from START until leaving BUSY; SHALL be 0 in IDLE.
REQ-027 In BUSY, a 6-bit saturating counter SHALL increment every cycle; md_resultRDY SHALL be ignored while counter < MIN_LAT.
REQ-028 In BUSY, on md_resultRDY with counter >= MIN_LAT, SHALL capture wb_data=md_result and wb_exception=md_exception, set wb_timeout=0, and go to DONE.
REQ-029 In BUSY, when counter reaches TIMEOUT without a qualifying md_resultRDY, SHALL go to DONE with wb_data=0, wb_exception=1, wb_timeout=1.
REQ-030 If a qualifying md_resultRDY and timeout occur in the same cycle, the result SHALL win (wb_timeout=0).
REQ-031 In DONE, wb_valid=1 and wb_data/rd/exception/timeout SHALL be held stable until wb_ready=1; on that edge, next state IDLE and wb_valid=0.
REQ-032 A new issue SHALL NOT be accepted in the DONE/wb_ready cycle; the earliest accept is the following IDLE cycle.
REQ-033 flush in any state SHALL force next state IDLE, drop the pending result, and deassert md_ctrl_*; flush wins over accept, md_resultRDY, timeout and wb_ready.
REQ-034 md_resultRDY in IDLE, START or DONE SHALL be ignored.
REQ-035 wb_* outputs SHALL be registered, not combinational from md_* inputs.

Reset
REQ-036 On reset_n=0, SHALL immediately force state IDLE, counter 0, and all outputs 0 (issue_ready=1 after release, busy=0).
REQ-037 Reset asserted mid-operation SHALL discard the operation; no wb_valid SHALL follow release.

Verification
REQ-038 Multiply 7 x -3, rd=5, multdiv RDY at counter 3, wb_ready=1 -> one md_ctrl_MULT pulse; wb_valid with wb_data=0xFFFFFFEB, wb_rd=5, exception=0.
REQ-039 Divide 100 / 0 -> no md_ctrl_DIV pulse; DONE the cycle after accept with wb_data=0, wb_exception=1, wb_timeout=0.
REQ-040 md_resultRDY held 0 -> wb_timeout=1, wb_exception=1 at counter 40; spurious RDY at counter 1 is ignored.
REQ-041 flush at counter 2 in BUSY, then RDY at counter 3 -> no wb_valid; busy=0 next cycle; next issue accepted.
REQ-042 wb_ready held 0 for 5 cycles in DONE -> wb_* stable and issue_ready=0 throughout; release -> IDLE.
REQ-043 reset_n pulsed low mid-BUSY -> all outputs 0 asynchronously; no result after release.
